// File: rtl/conv2_sched.sv
// Round-robin scheduler for the time-multiplexed conv2 filter banks.
// Windows are issued to banks in order; results are retired strictly in issue order.
module conv2_sched #(
  parameter int NUM_BANKS = 9,
  parameter int BANK_LAT  = 8,
  parameter int OUT_W     = 11,
  parameter int OUT_H     = 11
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 win_valid,
  output logic                 win_ready,
  output logic [NUM_BANKS-1:0] bank_load,
  output logic [3:0]           bank_sel,
  output logic                 res_valid,
  output logic [3:0]           res_sel,
  output logic [3:0]           out_x,
  output logic [3:0]           out_y,
  output logic                 busy,
  output logic                 frame_done
);

  localparam logic [7:0] TOTAL     = 8'(OUT_W * OUT_H);
  localparam logic [3:0] LAT       = 4'(BANK_LAT);
  localparam logic [3:0] LAST_BANK = 4'(NUM_BANKS - 1);
  localparam logic [3:0] LAST_X    = 4'(OUT_W - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  state_e               state_q, state_d;
  logic [NUM_BANKS-1:0] bank_busy_q, bank_busy_d;
  logic [3:0]           timer_q [NUM_BANKS];
  logic [3:0]           timer_d [NUM_BANKS];
  logic [3:0]           wr_ptr_q, wr_ptr_d;
  logic [3:0]           rd_ptr_q, rd_ptr_d;
  logic [7:0]           issued_q, issued_d;
  logic [7:0]           retired_q, retired_d;
  logic [NUM_BANKS-1:0] bank_load_q, bank_load_d;
  logic [3:0]           bank_sel_q, bank_sel_d;
  logic [3:0]           out_x_q, out_x_d;
  logic [3:0]           out_y_q, out_y_d;
  logic                 issue, retire;

  // A bank freed this cycle is still seen busy here, so there is no same-cycle reuse.
  assign win_ready  = (state_q == RUN) && !bank_busy_q[wr_ptr_q] && (issued_q < TOTAL);
  assign issue      = win_valid && win_ready;
  assign res_valid  = bank_busy_q[rd_ptr_q] && (timer_q[rd_ptr_q] == 4'd0);
  assign retire     = res_valid;
  assign res_sel    = rd_ptr_q;
  assign bank_load  = bank_load_q;
  assign bank_sel   = bank_sel_q;
  assign out_x      = out_x_q;
  assign out_y      = out_y_q;
  assign busy       = (state_q != IDLE);
  assign frame_done = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (issued_q == TOTAL) state_d = DRAIN;
      DRAIN:   if (retired_q == TOTAL) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bank_busy_d = bank_busy_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    issued_d    = issued_q;
    retired_d   = retired_q;
    out_x_d     = out_x_q;
    out_y_d     = out_y_q;
    bank_load_d = '0;
    bank_sel_d  = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      timer_d[i] = (timer_q[i] != 4'd0) ? timer_q[i] - 4'd1 : 4'd0;
    end

    if (state_q == IDLE && start) begin
      issued_d  = '0;
      retired_d = '0;
      out_x_d   = '0;
      out_y_d   = '0;
    end

    if (issue) begin
      bank_busy_d[wr_ptr_q] = 1'b1;
      timer_d[wr_ptr_q]     = LAT;
      wr_ptr_d              = (wr_ptr_q == LAST_BANK) ? 4'd0 : wr_ptr_q + 4'd1;
      issued_d              = issued_q + 8'd1;
      bank_load_d[wr_ptr_q] = 1'b1;
      bank_sel_d            = wr_ptr_q;
    end

    // Issue and retire always touch different banks: one needs busy clear, the other set.
    if (retire) begin
      bank_busy_d[rd_ptr_q] = 1'b0;
      rd_ptr_d              = (rd_ptr_q == LAST_BANK) ? 4'd0 : rd_ptr_q + 4'd1;
      retired_d             = retired_q + 8'd1;
      if (out_x_q == LAST_X) begin
        out_x_d = 4'd0;
        out_y_d = out_y_q + 4'd1;
      end else begin
        out_x_d = out_x_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bank_busy_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      issued_q    <= '0;
      retired_q   <= '0;
      bank_load_q <= '0;
      bank_sel_q  <= '0;
      out_x_q     <= '0;
      out_y_q     <= '0;
      for (int i = 0; i < NUM_BANKS; i++) timer_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      bank_busy_q <= bank_busy_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      issued_q    <= issued_d;
      retired_q   <= retired_d;
      bank_load_q <= bank_load_d;
      bank_sel_q  <= bank_sel_d;
      out_x_q     <= out_x_d;
      out_y_q     <= out_y_d;
      for (int i = 0; i < NUM_BANKS; i++) timer_q[i] <= timer_d[i];
    end
  end

endmodule
